ksa_mp_adder: RTL and testbench

Multi-precision sequential adder that sits directly upstream of the 16-bit Kogge-Stone adder core and consumes its result. It accepts WIDTH-bit operands over a valid/ready handshake. It then feeds the core one 16-bit limb per cycle, LSB limb first, and chains the core's carry-out into the next limb's carry-in through a register. It returns the full WIDTH-bit sum with carry-out and signed overflow over a second valid/ready handshake.

---
 rtl/ksa_pkg.sv | 20 ++
 rtl/ksa_16bit.sv | 60 ++++++
 rtl/ksa_mp_adder.sv | 135 +++++++++++++
 tb/tb_ksa_mp_adder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ksa_pkg.sv
// ksa_pkg - shared definitions for the multi-precision Kogge-Stone adder.
//   LIMB_W    : width of one limb, which is also the width of the ksa_16bit core
//   state_t   : sequencer states (IDLE / RUN / DONE)
//   cnt_width : width of the limb counter for a given limb count (minimum 1 bit)
package ksa_pkg;

    localparam int LIMB_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-limb build still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ksa_16bit.sv
// ksa_16bit - 16-bit Kogge-Stone parallel-prefix adder core (combinational).
//   a, b : 16-bit operands
//   ci   : carry-in
//   sum  : 16-bit sum
//   co   : carry-out
module ksa_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic [15:0] sum,
    output logic        co
);

    logic [15:0] g0;
    logic [15:0] p0;
    logic [16:0] carry;

    assign g0 = a & b;
    assign p0 = a ^ b;

    // Four prefix levels with span 1, 2, 4, 8. After the last level,
    // lvl[3].g_out[i] / p_out[i] are the group generate/propagate of bits i..0.
    genvar gl, gi;
    generate
        for (gl = 0; gl < 4; gl++) begin : lvl
            logic [15:0] g_in;
            logic [15:0] p_in;
            logic [15:0] g_out;
            logic [15:0] p_out;

            if (gl == 0) begin : src_first
                assign g_in = g0;
                assign p_in = p0;
            end else begin : src_prev
                assign g_in = lvl[gl-1].g_out;
                assign p_in = lvl[gl-1].p_out;
            end

            for (gi = 0; gi < 16; gi++) begin : bit_op
                if (gi >= (1 << gl)) begin : merge
                    assign g_out[gi] = g_in[gi] | (p_in[gi] & g_in[gi - (1 << gl)]);
                    assign p_out[gi] = p_in[gi] & p_in[gi - (1 << gl)];
                end else begin : pass
                    assign g_out[gi] = g_in[gi];
                    assign p_out[gi] = p_in[gi];
                end
            end
        end

        // The carry-in is folded in once at the end rather than as a bit -1.
        assign carry[0] = ci;
        for (gi = 0; gi < 16; gi++) begin : carry_gen
            assign carry[gi+1] = lvl[3].g_out[gi] | (lvl[3].p_out[gi] & ci);
        end
    endgenerate

    assign sum = p0 ^ carry[15:0];
    assign co  = carry[16];

endmodule

// File: rtl/ksa_mp_adder.sv
// ksa_mp_adder - multi-precision sequential adder built on one ksa_16bit core.
// Operands are accepted over in_valid/in_ready, added one 16-bit limb per cycle
// (LSB limb first, carry chained through carry_reg), and the WIDTH-bit result
// with carry-out and signed overflow is returned over out_valid/out_ready.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake (a, b, ci[, sub])
//   out_valid, out_ready: result handshake (sum, co, ovf)
// Optional macro KSA_MP_SUB_EN adds the sub port: sub=1 computes a - b
// (B inverted, limb-0 carry forced to 1, ci ignored; co=1 means no borrow).
module ksa_mp_adder
    import ksa_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef KSA_MP_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int NUM_WORDS = WIDTH / LIMB_W;
    localparam int CNT_W     = cnt_width(NUM_WORDS);

    state_t                   state_reg, state_next;
    logic [WIDTH-1:0]         a_reg, b_reg, sum_reg;
    logic                     carry_reg, co_reg, ovf_reg;
    logic [CNT_W-1:0]         cnt_reg;

    logic [WIDTH-1:0]         b_cap;
    logic                     ci_cap;
    logic [LIMB_W-1:0]        core_sum;
    logic                     core_co;
    logic                     last_limb;
    logic [WIDTH+LIMB_W-1:0]  sum_shift;

    // B is stored already inverted for subtraction, so b_reg is b_eff and
    // the overflow rule can look at it directly.
    always_comb begin
        b_cap  = b;
        ci_cap = ci;
`ifdef KSA_MP_SUB_EN
        if (sub) begin
            b_cap  = ~b;
            ci_cap = 1'b1;
        end
`endif
    end

    ksa_16bit u_core (
        .a   (a_reg[LIMB_W-1:0]),
        .b   (b_reg[LIMB_W-1:0]),
        .ci  (carry_reg),
        .sum (core_sum),
        .co  (core_co)
    );

    assign last_limb = (cnt_reg == CNT_W'(NUM_WORDS - 1));
    // New limb enters at the top; after NUM_WORDS shifts limb 0 sits at the bottom.
    assign sum_shift = {core_sum, sum_reg};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_limb) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            co_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b_cap;
                        carry_reg <= ci_cap;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> LIMB_W;
                    b_reg     <= b_reg >> LIMB_W;
                    carry_reg <= core_co;
                    sum_reg   <= sum_shift[WIDTH+LIMB_W-1:LIMB_W];
                    if (last_limb) begin
                        // The low limb now holds the original top limb, so its
                        // bit 15 is the operand sign bit.
                        co_reg  <= core_co;
                        ovf_reg <= (a_reg[LIMB_W-1] == b_reg[LIMB_W-1]) &&
                                   (core_sum[LIMB_W-1] != a_reg[LIMB_W-1]);
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign sum       = sum_reg;
    assign co        = co_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_ksa_mp_adder.sv
// tb_ksa_mp_adder - self-checking bench for ksa_mp_adder (WIDTH=64).
// Directed scenarios plus randomized transactions, all checked against a
// plain-arithmetic reference model.
module tb_ksa_mp_adder;

    localparam int WIDTH     = 64;
    localparam int NUM_WORDS = WIDTH / 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ksa_mp_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
`ifdef KSA_MP_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, wait for result, compare with the model,
    // optionally stall the output for bp cycles, then complete the handshake.
    task automatic do_op(input string name, input logic [63:0] ta, input logic [63:0] tb_v,
                         input logic tci, input logic tsub, input int bp);
        logic [64:0] full;
        logic [63:0] b_eff;
        logic        cin;
        logic [63:0] exp_sum;
        logic        exp_co, exp_ovf;
        logic [63:0] held_sum;
        logic        held_co, held_ovf;
        int          waited;
        int          lat;

`ifdef KSA_MP_SUB_EN
        b_eff = tsub ? ~tb_v : tb_v;
        cin   = tsub ? 1'b1 : tci;
`else
        b_eff = tb_v;
        cin   = tci;
`endif
        full    = {1'b0, ta} + {1'b0, b_eff} + {64'd0, cin};
        exp_sum = full[63:0];
        exp_co  = full[64];
        exp_ovf = (ta[63] == b_eff[63]) && (exp_sum[63] != ta[63]);

        waited = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            check({name, "_in_ready_timeout"}, {63'd0, in_ready}, 64'd1);
            return;
        end

        a        = ta;
        b        = tb_v;
        ci       = tci;
        sub      = tsub;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = ~ta;
        b        = '0;
        check({name, "_busy_in_ready"}, {63'd0, in_ready}, 64'd0);

        lat = 1;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (!out_valid) begin
            check({name, "_out_valid_timeout"}, {63'd0, out_valid}, 64'd1);
            return;
        end
        check({name, "_latency"}, 64'(lat), 64'(NUM_WORDS + 1));
        check({name, "_sum"}, sum, exp_sum);
        check({name, "_co"}, {63'd0, co}, {63'd0, exp_co});
        check({name, "_ovf"}, {63'd0, ovf}, {63'd0, exp_ovf});
        $display("op %-10s a=%h b=%h ci=%0d sub=%0d -> sum=%h co=%0d ovf=%0d",
                 name, ta, tb_v, tci, tsub, sum, co, ovf);

        held_sum = sum;
        held_co  = co;
        held_ovf = ovf;
        // A competing request during the stall must be ignored.
        in_valid = (bp > 0);
        for (int i = 0; i < bp; i++) begin
            tick();
            check({name, "_bp_out_valid"}, {63'd0, out_valid}, 64'd1);
            check({name, "_bp_in_ready"}, {63'd0, in_ready}, 64'd0);
            check({name, "_bp_sum"}, sum, held_sum);
            check({name, "_bp_co_ovf"}, {62'd0, co, ovf}, {62'd0, held_co, held_ovf});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_post_out_valid"}, {63'd0, out_valid}, 64'd0);
        check({name, "_post_in_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic [63:0] ra, rb;
        int          sel;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        sub       = 1'b0;
        repeat (3) tick();
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_sum", sum, 64'd0);
        check("reset_co_ovf", {62'd0, co, ovf}, 64'd0);
        rst = 1'b0;
        tick();

        do_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0);
        do_op("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0);
        do_op("ci_limb", 64'h0000_0000_0000_FFFF, 64'd0, 1'b1, 1'b0, 0);
        do_op("backpress", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b1, 1'b0, 3);

        // Reset on the second RUN cycle discards the operation.
        a        = 64'h1234_5678_9ABC_DEF0;
        b        = 64'h1111_1111_1111_1111;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_sum", sum, 64'd0);
        check("midrst_co_ovf", {62'd0, co, ovf}, 64'd0);
        $display("op midrst     reset applied on second RUN cycle");
        do_op("after_rst", 64'd3, 64'd4, 1'b0, 1'b0, 0);

`ifdef KSA_MP_SUB_EN
        do_op("sub_neg", 64'd5, 64'd7, 1'b1, 1'b1, 0);
        do_op("sub_pos", 64'd7, 64'd5, 1'b0, 1'b1, 1);
`endif

        for (int t = 0; t < 30; t++) begin
            sel = $urandom_range(0, 3);
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            if (sel == 1) rb = ~ra;                      // long carry propagate
            if (sel == 2) ra = {ra[63], {15{ra[63]}}, ra[47:0]};
            do_op("random", ra, rb, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
